// File: rtl/seg_display_driver_pkg.sv
// Shared definitions for the multiplexed 7-segment display peripheral.
// Register map, reset values and the hex-to-segment table.
package seg_display_driver_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_DP     = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam logic [31:0] RST_DATA = 32'h0;
  localparam logic [7:0]  RST_MASK = 8'hFF;
  localparam logic [7:0]  RST_DP   = 8'h00;

  // Active-high {g,f,e,d,c,b,a}; entry 15 first.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_display_driver_hex_decoder.sv
// Nibble to active-high {g..a} segment pattern.
// Purely combinational.
module seg_hex_decoder
  import seg_display_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_display_driver.sv
// CPU-writable 8-digit multiplexed 7-segment display driver.
// Round-robin digit scan with blanking at the start of each slot.
module seg_display_driver
  import seg_display_driver_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [7:0]  seg_n,
  output logic [7:0]  an_n
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK = CW'(BLANK_CYC);

  logic [31:0]   data_q;
  logic [7:0]    mask_q;
  logic [7:0]    dp_q;
  logic [CW-1:0] div_cnt;
  logic [2:0]    idx;
  logic [3:0]    nibble;
  logic [6:0]    code;
  logic          blank;

  assign nibble = data_q[{idx, 2'b00} +: 4];
  assign blank  = (div_cnt < BLANK) || !mask_q[idx];

  seg_hex_decoder u_dec (
    .nibble (nibble),
    .seg    (code)
  );

  always_comb begin
    data_out = 32'h0;
    unique case (addr)
      ADDR_DATA:   data_out = data_q;
      ADDR_MASK:   data_out = {24'h0, mask_q};
      ADDR_DP:     data_out = {24'h0, dp_q};
      ADDR_STATUS: data_out = {29'h0, idx};
      default:     data_out = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RST_DATA;
      mask_q <= RST_MASK;
      dp_q   <= RST_DP;
    end else if (we) begin
      unique case (addr)
        ADDR_DATA: data_q <= data_in;
        ADDR_MASK: mask_q <= data_in[7:0];
        ADDR_DP:   dp_q   <= data_in[7:0];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      idx     <= 3'd0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
      idx     <= idx + 3'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Outputs lag the scan state by one cycle; blanking hides the switch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_n <= 8'hFF;
      an_n  <= 8'hFF;
    end else if (blank) begin
      seg_n <= 8'hFF;
      an_n  <= 8'hFF;
    end else begin
      seg_n <= ~{dp_q[idx], code};
      an_n  <= ~(8'h01 << idx);
    end
  end

endmodule
